mem_store_buffer: RTL and testbench
===================================

MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4: store-buffer entries; power of two, 2..16.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port MemWrite_mem, input, 1: MEM-stage store request.
REQ-005 SHALL have port MemRead_mem, input, 1: MEM-stage load request.
REQ-006 SHALL have port Addr_mem, input, 32: byte address; bits [1:0] ignored (word access only).
REQ-007 SHALL have port WriteData_mem, input, 32: store data.
REQ-008 SHALL have port ReadData_mem, output, 32: load data to the MEM/WB register.
REQ-009 SHALL have port MemStall, output, 1: freezes the pipeline at MEM; the CPU holds all MEM-side inputs stable while it is 1.
REQ-010 SHALL have port mem_req, output, 1: memory transaction request (registered).
REQ-011 SHALL have port mem_we, output, 1: 1 = write, 0 = read (registered).
REQ-012 SHALL have port mem_addr, output, 32: word-aligned memory address (registered).
REQ-013 SHALL have port mem_wdata, output, 32: memory write data (registered).
REQ-014 SHALL have port mem_rdata, input, 32: memory read data, valid in the mem_ack cycle.
REQ-015 SHALL have port mem_ack, input, 1: one-cycle completion pulse for the current request.
REQ-016 SHALL have port BufEmpty, output, 1: 1 when the store buffer holds no entries.

Function
REQ-017 SHALL keep a FIFO of DEPTH {word address [31:2], data} entries, with a count register of width log2(DEPTH)+1.
REQ-018 Store with count<DEPTH SHALL be pushed at the clock edge, with MemStall=0 in that cycle.
REQ-019 Store with count==DEPTH SHALL assert MemStall and be pushed in the first cycle with count<DEPTH; a pop in the same cycle does not relieve full.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; stores SHALL NOT be coalesced (same address = new entry).
REQ-021 Load hit (Addr_mem[31:2] matches any valid entry, including the head being drained) SHALL drive ReadData_mem combinationally with the youngest match, MemStall=0.
REQ-022 Load miss SHALL be served by a memory read; MemStall=1 until data is returned.
REQ-023 FSM states SHALL be IDLE, WR_BUSY, RD_BUSY, RD_DONE.
REQ-024 IDLE SHALL go to RD_BUSY on a load miss, which has priority over draining.
REQ-025 IDLE SHALL otherwise go to WR_BUSY when count>0, loading mem_addr/mem_wdata from the head entry with mem_we=1.
REQ-026 In WR_BUSY and RD_BUSY, mem_req=1 and mem_addr/mem_we/mem_wdata SHALL be held stable until mem_ack.
REQ-027 WR_BUSY with mem_ack SHALL pop the head and go to IDLE, with mem_req=0 the next cycle.
REQ-028 RD_BUSY with mem_ack SHALL capture mem_rdata into a read register and go to RD_DONE.
REQ-029 RD_DONE SHALL drive ReadData_mem from the read register with MemStall=0, then go to IDLE unconditionally.
REQ-030 Load-miss timing: load presented in IDLE at cycle t; mem_req=1 from t+1; ack at t+1+k; MemStall=1 for cycles t..t+1+k and 0 at t+2+k; minimum stall is 2 cycles.
REQ-031 A load miss presented during WR_BUSY SHALL wait for that write to complete, then issue from IDLE.
REQ-032 ReadData_mem SHALL be 0 when there is no load hit and the state is not RD_DONE.
REQ-033 MemWrite_mem and MemRead_mem asserted together is illegal; the store SHALL take priority and the load SHALL be ignored.
REQ-034 mem_ack in IDLE or RD_DONE SHALL be ignored.

Reset
REQ-035 On reset: state=IDLE, count=0, pointers=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, read register=0, BufEmpty=1, MemStall=0.
REQ-036 Reset mid-transaction SHALL abandon the request (mem_req=0 next cycle) and discard all buffered stores.

Verification
REQ-037 Reset, then 4 stores to 0x10,0x14,0x18,0x1C with mem_ack tied 0 -> no stall; 5th store sees MemStall=1; mem_req=1 with mem_addr=0x10, mem_we=1.
REQ-038 Store 0x20=0xAAAA then store 0x20=0xBBBB, then load 0x20 -> ReadData_mem=0xBBBB same cycle, MemStall=0, no read issued.
REQ-039 Empty buffer, load 0x40, ack 3 cycles after mem_req rises with mem_rdata=0x1234 -> MemStall high 5 cycles, ReadData_mem=0x1234 in the following cycle.
REQ-040 Two buffered stores, load miss 0x80 in IDLE -> read issued before any write; writes drain afterwards in FIFO order.
REQ-041 Reset asserted during RD_BUSY with 3 entries buffered -> next cycle mem_req=0, BufEmpty=1, MemStall=0; a later ack is ignored.

Source files
------------

// File: rtl/mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : mem_store_buffer
// Brief    : MEM-stage store buffer. Stores are queued in a small FIFO and
//            drained to memory in the background. Loads are forwarded from the
//            youngest matching buffered store, or served by a memory read.
//            A read miss takes priority over draining.
// Revision : 1.0 - initial release
// ============================================================================
module mem_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite_mem,
    input  logic        MemRead_mem,
    input  logic [31:0] Addr_mem,
    input  logic [31:0] WriteData_mem,
    output logic [31:0] ReadData_mem,
    output logic        MemStall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        BufEmpty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;

    // FIFO storage: word address and data per entry
    logic [29:0]        buf_addr_q [DEPTH];
    logic [31:0]        buf_data_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // Registered memory-side request and captured read data
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [31:0]        rd_data_q, rd_data_d;

    logic               full;
    logic               push;
    logic               pop;
    logic               load_req;
    logic               load_miss;
    logic               hit;
    logic [31:0]        hit_data;
    logic               w_unused_addr_lsb;

    // Word access only: the byte offset carries no information
    assign w_unused_addr_lsb = ^Addr_mem[1:0];

    // Full is judged on the current count; a same-cycle pop does not free a slot
    assign full      = (count_q == FULL_CNT);
    assign push      = MemWrite_mem && !full;
    assign pop       = (state_q == WR_BUSY) && mem_ack;
    // A store presented together with a load wins; the load is dropped
    assign load_req  = MemRead_mem && !MemWrite_mem;
    assign load_miss = load_req && !hit;

    // Search valid entries oldest-to-youngest so the youngest match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (buf_addr_q[rd_ptr_q + PTR_W'(k)] == Addr_mem[31:2])) begin
                hit      = 1'b1;
                hit_data = buf_data_q[rd_ptr_q + PTR_W'(k)];
            end
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Controller next-state and memory-request next-state
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rd_data_d   = rd_data_q;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_d    = RD_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {Addr_mem[31:2], 2'b00};
                end else if (count_q != '0) begin
                    state_d     = WR_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {buf_addr_q[rd_ptr_q], 2'b00};
                    mem_wdata_d = buf_data_q[rd_ptr_q];
                end
            end
            WR_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            RD_BUSY: begin
                if (mem_ack) begin
                    state_d   = RD_DONE;
                    mem_req_d = 1'b0;
                    rd_data_d = mem_rdata;
                end
            end
            RD_DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pipeline-facing outputs: forwarding, read return and stall
    always_comb begin
        ReadData_mem = '0;
        MemStall     = 1'b0;
        if (state_q == RD_DONE) begin
            ReadData_mem = rd_data_q;
        end else if (load_req && hit) begin
            ReadData_mem = hit_data;
        end
        if (MemWrite_mem) begin
            MemStall = full;
        end else if (MemRead_mem) begin
            MemStall = (state_q != RD_DONE) && !hit;
        end
    end

    // State, pointers and memory-request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Entry storage; contents are only meaningful below count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= Addr_mem[31:2];
            buf_data_q[wr_ptr_q] <= WriteData_mem;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign BufEmpty  = (count_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_mem_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_store_buffer
// Brief    : Directed vector bench for mem_store_buffer (DEPTH = 4). Each
//            vector is one clock cycle: inputs applied after the rising edge,
//            outputs compared at the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_store_buffer;

    logic        clk;
    logic        reset;
    logic        MemWrite_mem;
    logic        MemRead_mem;
    logic [31:0] Addr_mem;
    logic [31:0] WriteData_mem;
    logic [31:0] ReadData_mem;
    logic        MemStall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        BufEmpty;

    mem_store_buffer #(.DEPTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .MemWrite_mem  (MemWrite_mem),
        .MemRead_mem   (MemRead_mem),
        .Addr_mem      (Addr_mem),
        .WriteData_mem (WriteData_mem),
        .ReadData_mem  (ReadData_mem),
        .MemStall      (MemStall),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .mem_ack       (mem_ack),
        .BufEmpty      (BufEmpty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One cycle: inputs, then expected outputs for that same cycle
    typedef struct {
        logic [31:0] rst, wr, rd, addr, wd, rdat, ack;
        logic [31:0] e_rd, e_stall, e_req, e_we, e_addr, e_wd, e_empty;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t tbl[$];

    function automatic vec_t v(
        input logic [31:0] rst, wr, rd, addr, wd, rdat, ack,
        input logic [31:0] e_rd, e_stall, e_req, e_we, e_addr, e_wd, e_empty);
        vec_t t;
        t.rst = rst; t.wr = wr; t.rd = rd; t.addr = addr; t.wd = wd;
        t.rdat = rdat; t.ack = ack;
        t.e_rd = e_rd; t.e_stall = e_stall; t.e_req = e_req; t.e_we = e_we;
        t.e_addr = e_addr; t.e_wd = e_wd; t.e_empty = e_empty;
        return t;
    endfunction

    task automatic chk(input string tag, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h, expected %h", tag, nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input string tag);
        reset         = t.rst[0];
        MemWrite_mem  = t.wr[0];
        MemRead_mem   = t.rd[0];
        Addr_mem      = t.addr;
        WriteData_mem = t.wd;
        mem_rdata     = t.rdat;
        mem_ack       = t.ack[0];
        @(negedge clk);
        n_vec++;
        chk(tag, "ReadData_mem", ReadData_mem,     t.e_rd);
        chk(tag, "MemStall",     32'(MemStall),    t.e_stall);
        chk(tag, "mem_req",      32'(mem_req),     t.e_req);
        chk(tag, "mem_we",       32'(mem_we),      t.e_we);
        chk(tag, "mem_addr",     mem_addr,         t.e_addr);
        chk(tag, "mem_wdata",    mem_wdata,        t.e_wd);
        chk(tag, "BufEmpty",     32'(BufEmpty),    t.e_empty);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            rst wr rd addr    wd       rdat     ack | rd       stl req we addr    wd       empty
        // Reset state
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,0,'h0,   'h0,    1));
        // Fill to DEPTH with ack held low; 5th store stalls; pop does not relieve full
        tbl.push_back(v(0,1,0,'h10,  'h1111, 'h0,    0,  'h0,    0,0,0,'h0,   'h0,    1));
        tbl.push_back(v(0,1,0,'h14,  'h2222, 'h0,    0,  'h0,    0,0,0,'h0,   'h0,    0));
        tbl.push_back(v(0,1,0,'h18,  'h3333, 'h0,    0,  'h0,    0,1,1,'h10,  'h1111, 0));
        tbl.push_back(v(0,1,0,'h1C,  'h4444, 'h0,    0,  'h0,    0,1,1,'h10,  'h1111, 0));
        tbl.push_back(v(0,1,0,'h20,  'h5555, 'h0,    0,  'h0,    1,1,1,'h10,  'h1111, 0));
        tbl.push_back(v(0,1,0,'h20,  'h5555, 'h0,    1,  'h0,    1,1,1,'h10,  'h1111, 0));
        tbl.push_back(v(0,1,0,'h20,  'h5555, 'h0,    0,  'h0,    0,0,1,'h10,  'h1111, 0));
        // Forwarding from a middle entry and from the head being drained
        tbl.push_back(v(0,0,1,'h1C,  'h0,    'h0,    0,  'h4444, 0,1,1,'h14,  'h2222, 0));
        tbl.push_back(v(0,0,1,'h14,  'h0,    'h0,    1,  'h2222, 0,1,1,'h14,  'h2222, 0));
        // Drain remaining entries in order
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h14,  'h2222, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    1,  'h0,    0,1,1,'h18,  'h3333, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h18,  'h3333, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    1,  'h0,    0,1,1,'h1C,  'h4444, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h1C,  'h4444, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    1,  'h0,    0,1,1,'h20,  'h5555, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h20,  'h5555, 1));
        // Same address stored twice: youngest forwarded, both written
        tbl.push_back(v(0,1,0,'h20,  'hAAAA, 'h0,    0,  'h0,    0,0,1,'h20,  'h5555, 1));
        tbl.push_back(v(0,1,0,'h20,  'hBBBB, 'h0,    0,  'h0,    0,0,1,'h20,  'h5555, 0));
        tbl.push_back(v(0,0,1,'h20,  'h0,    'h0,    0,  'hBBBB, 0,1,1,'h20,  'hAAAA, 0));
        tbl.push_back(v(0,0,1,'h20,  'h0,    'h0,    1,  'hBBBB, 0,1,1,'h20,  'hAAAA, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h20,  'hAAAA, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    1,  'h0,    0,1,1,'h20,  'hBBBB, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h20,  'hBBBB, 1));
        // Load miss on empty buffer, ack 3 cycles after mem_req rises: 5 stall cycles
        tbl.push_back(v(0,0,1,'h40,  'h0,    'h0,    0,  'h0,    1,0,1,'h20,  'hBBBB, 1));
        tbl.push_back(v(0,0,1,'h40,  'h0,    'h0,    0,  'h0,    1,1,0,'h40,  'hBBBB, 1));
        tbl.push_back(v(0,0,1,'h40,  'h0,    'h0,    0,  'h0,    1,1,0,'h40,  'hBBBB, 1));
        tbl.push_back(v(0,0,1,'h40,  'h0,    'h0,    0,  'h0,    1,1,0,'h40,  'hBBBB, 1));
        tbl.push_back(v(0,0,1,'h40,  'h0,    'h1234, 1,  'h0,    1,1,0,'h40,  'hBBBB, 1));
        tbl.push_back(v(0,0,1,'h40,  'h0,    'hDEAD, 1,  'h1234, 0,0,0,'h40,  'hBBBB, 1));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'hDEAD, 1,  'h0,    0,0,0,'h40,  'hBBBB, 1));
        // Two buffered stores, load miss in IDLE: read first, then drain in order
        tbl.push_back(v(0,1,0,'h60,  'h6060, 'h0,    0,  'h0,    0,0,0,'h40,  'hBBBB, 1));
        tbl.push_back(v(0,1,0,'h64,  'h6464, 'h0,    0,  'h0,    0,0,0,'h40,  'hBBBB, 0));
        tbl.push_back(v(0,1,0,'h68,  'h6868, 'h0,    1,  'h0,    0,1,1,'h60,  'h6060, 0));
        tbl.push_back(v(0,0,1,'h80,  'h0,    'h0,    0,  'h0,    1,0,1,'h60,  'h6060, 0));
        tbl.push_back(v(0,0,1,'h80,  'h0,    'hCAFE, 1,  'h0,    1,1,0,'h80,  'h6060, 0));
        tbl.push_back(v(0,0,1,'h80,  'h0,    'h0,    0,  'hCAFE, 0,0,0,'h80,  'h6060, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,0,'h80,  'h6060, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    1,  'h0,    0,1,1,'h64,  'h6464, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h64,  'h6464, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    1,  'h0,    0,1,1,'h68,  'h6868, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h68,  'h6868, 1));
        // Store and load together: store wins, load ignored; byte offset dropped
        tbl.push_back(v(0,1,1,'h93,  'h9090, 'h0,    0,  'h0,    0,0,1,'h68,  'h6868, 1));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h68,  'h6868, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    1,  'h0,    0,1,1,'h90,  'h9090, 0));
        tbl.push_back(v(0,0,0,'h0,   'h0,    'h0,    0,  'h0,    0,0,1,'h90,  'h9090, 1));

        // Initial reset, outputs not checked until it has taken effect
        reset = 1'b1; MemWrite_mem = 1'b0; MemRead_mem = 1'b0;
        Addr_mem = '0; WriteData_mem = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl[%0d]", i));
        end

        // Load miss arriving during a write waits for it, then issues from IDLE
        apply(v(0,1,0,'hA0, 'hA0A0, 'h0,    0, 'h0,    0,0,1,'h90, 'h9090, 1), "wait1");
        apply(v(0,1,0,'hA4, 'hA4A4, 'h0,    0, 'h0,    0,0,1,'h90, 'h9090, 0), "wait2");
        apply(v(0,0,1,'hC0, 'h0,    'h0,    0, 'h0,    1,1,1,'hA0, 'hA0A0, 0), "wait3");
        apply(v(0,0,1,'hC0, 'h0,    'h0,    1, 'h0,    1,1,1,'hA0, 'hA0A0, 0), "wait4");
        apply(v(0,0,1,'hC0, 'h0,    'h0,    0, 'h0,    1,0,1,'hA0, 'hA0A0, 0), "wait5");
        apply(v(0,0,1,'hC0, 'h0,    'h5A5A, 1, 'h0,    1,1,0,'hC0, 'hA0A0, 0), "wait6");
        apply(v(0,0,1,'hC0, 'h0,    'h0,    0, 'h5A5A, 0,0,0,'hC0, 'hA0A0, 0), "wait7");
        apply(v(0,0,0,'h0,  'h0,    'h0,    0, 'h0,    0,0,0,'hC0, 'hA0A0, 0), "wait8");
        apply(v(0,0,0,'h0,  'h0,    'h0,    1, 'h0,    0,1,1,'hA4, 'hA4A4, 0), "wait9");
        apply(v(0,0,0,'h0,  'h0,    'h0,    0, 'h0,    0,0,1,'hA4, 'hA4A4, 1), "wait10");

        // Reset during RD_BUSY with 3 entries: request dropped, entries discarded
        apply(v(0,1,0,'hB0, 'hB0B0, 'h0,    0, 'h0,    0,0,1,'hA4, 'hA4A4, 1), "rst1");
        apply(v(0,1,0,'hB4, 'hB4B4, 'h0,    0, 'h0,    0,0,1,'hA4, 'hA4A4, 0), "rst2");
        apply(v(0,1,0,'hB8, 'hB8B8, 'h0,    0, 'h0,    0,1,1,'hB0, 'hB0B0, 0), "rst3");
        apply(v(0,1,0,'hBC, 'hBCBC, 'h0,    1, 'h0,    0,1,1,'hB0, 'hB0B0, 0), "rst4");
        apply(v(0,0,1,'hE0, 'h0,    'h0,    0, 'h0,    1,0,1,'hB0, 'hB0B0, 0), "rst5");
        apply(v(0,0,1,'hE0, 'h0,    'h0,    0, 'h0,    1,1,0,'hE0, 'hB0B0, 0), "rst6");
        apply(v(1,0,0,'h0,  'h0,    'h0,    0, 'h0,    0,1,0,'hE0, 'hB0B0, 0), "rst7");
        apply(v(0,0,0,'h0,  'h0,    'hBAD,  1, 'h0,    0,0,0,'h0,  'h0,    1), "rst8");
        apply(v(0,0,1,'hB4, 'h0,    'h0,    0, 'h0,    1,0,0,'h0,  'h0,    1), "rst9");
        apply(v(0,0,1,'hB4, 'h0,    'h77,   1, 'h0,    1,1,0,'hB4, 'h0,    1), "rst10");
        apply(v(0,0,1,'hB4, 'h0,    'h0,    0, 'h77,   0,0,0,'hB4, 'h0,    1), "rst11");
        apply(v(0,0,0,'h0,  'h0,    'h0,    0, 'h0,    0,0,0,'hB4, 'h0,    1), "rst12");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
